// File: rtl/cnn_layer_sequencer_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM states, table-entry and
// config-word field positions, and the per-layer address step helper.
package cnn_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    localparam int ENTRY_W        = 9;
    localparam int ENTRY_CONV_BIT = 0;
    localparam int ENTRY_BIAS_LSB = 1;
    localparam int ENTRY_ACT_LSB  = 6;

    localparam int CFG_FIRST_BIT   = 0;
    localparam int CFG_LAST_LO_BIT = 1;
    localparam int CFG_CONV_BIT    = 2;
    localparam int CFG_LAST_HI_BIT = 3;
    localparam int CFG_INDEX_LSB   = 4;
    localparam int CFG_BIAS_LSB    = 8;
    localparam int CFG_ACT_LSB     = 13;

    // Weight words consumed by one 3x3 layer across all parallel kernels.
    function automatic int weight_step_3x3(int ti, int kernels, int words);
        return ti * kernels * 9 / words;
    endfunction

    function automatic logic [31:0] pack_config(logic [ENTRY_W-1:0] entry, logic [3:0] index,
                                                logic is_first, logic is_last);
        logic [31:0] cfg;
        cfg                       = '0;
        cfg[CFG_FIRST_BIT]        = is_first;
        cfg[CFG_LAST_LO_BIT]      = is_last;
        cfg[CFG_CONV_BIT]         = entry[ENTRY_CONV_BIT];
        cfg[CFG_LAST_HI_BIT]      = is_last;
        cfg[CFG_INDEX_LSB +: 4]   = index;
        cfg[CFG_BIAS_LSB +: 5]    = entry[ENTRY_BIAS_LSB +: 5];
        cfg[CFG_ACT_LSB +: 3]     = entry[ENTRY_ACT_LSB +: 3];
        return cfg;
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_table.sv
// Layer table: DEPTH x 9-bit register file, one write port, one
// combinational read port, cleared on reset.
module cnn_layer_table
    import cnn_layer_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               we,
    input  logic [3:0]         wr_idx,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [3:0]         rd_idx,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == 4'(i)) mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == 4'(i)) rd_data = mem[i];
        end
    end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Walks the layer table, issuing one config/base-address/start handshake per
// layer to the accelerator and pulsing net_done after the last one.
module cnn_layer_sequencer
    import cnn_layer_sequencer_pkg::*;
#(
    parameter int TI         = 16,
    parameter int TO         = 16,
    parameter int N          = 16,
    parameter int MAX_LAYERS = 8
)(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        i_cfg_we,
    input  logic [2:0]  i_cfg_idx,
    input  logic [8:0]  i_cfg_data,
    input  logic [3:0]  i_num_layers,
    input  logic [19:0] i_base_weight0,
    input  logic [11:0] i_base_param0,
    input  logic        i_run,
    input  logic        i_abort,
    input  logic        i_layer_done,
    output logic [31:0] o_layer_config,
    output logic [31:0] o_base_addr,
    output logic        o_layer_start,
    output logic [3:0]  o_layer_index,
    output logic        o_busy,
    output logic        o_net_done
);

    localparam logic [19:0] W_STEP_3X3 = 20'(weight_step_3x3(TI, TO, N));
    localparam logic [19:0] W_STEP_1X1 = 20'(TO);
    localparam logic [11:0] P_STEP     = 12'(TO);

    seq_state_e         state, state_next;
    logic [3:0]         layer_count, layer_idx, idx_inc, run_count;
    logic [19:0]        weight_base;
    logic [11:0]        param_base;
    logic               done_q, done_rise;
    logic               is_first, is_last;
    logic [ENTRY_W-1:0] entry;

    cnn_layer_table #(.DEPTH(MAX_LAYERS)) u_table (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .we      (i_cfg_we && (state == ST_IDLE)),
        .wr_idx  ({1'b0, i_cfg_idx}),
        .wr_data (i_cfg_data),
        .rd_idx  (layer_idx),
        .rd_data (entry)
    );

    assign run_count = (int'(i_num_layers) > MAX_LAYERS) ? 4'(MAX_LAYERS) : i_num_layers;
    assign idx_inc   = layer_idx + 4'd1;
    assign done_rise = i_layer_done && !done_q;
    assign is_first  = (layer_idx == 4'd0);
    assign is_last   = (layer_idx == layer_count - 4'd1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (i_abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (i_run) state_next = (run_count == 4'd0) ? ST_DONE : ST_CFG;
                ST_CFG:   state_next = ST_START;
                ST_START: state_next = ST_WAIT;
                ST_WAIT:  if (done_rise) state_next = ST_NEXT;
                ST_NEXT:  state_next = (idx_inc < layer_count) ? ST_CFG : ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Pulses are derived from the next state so every output stays registered;
    // an abort steers state_next to IDLE and therefore suppresses them.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            done_q         <= 1'b0;
            o_busy         <= 1'b0;
            o_layer_start  <= 1'b0;
            o_net_done     <= 1'b0;
            o_layer_config <= '0;
            o_base_addr    <= '0;
            o_layer_index  <= '0;
            layer_count    <= '0;
            layer_idx      <= '0;
            weight_base    <= '0;
            param_base     <= '0;
        end else begin
            done_q        <= i_layer_done;
            o_busy        <= (state_next != ST_IDLE);
            o_layer_start <= (state_next == ST_START);
            o_net_done    <= (state == ST_DONE) && !i_abort;
            if (!i_abort) begin
                case (state)
                    ST_IDLE: if (i_run) begin
                        layer_count <= run_count;
                        layer_idx   <= '0;
                        weight_base <= i_base_weight0;
                        param_base  <= i_base_param0;
                    end
                    ST_CFG: begin
                        o_layer_config <= pack_config(entry, layer_idx, is_first, is_last);
                        o_base_addr    <= {param_base, weight_base};
                        o_layer_index  <= layer_idx;
                    end
                    ST_NEXT: begin
                        weight_base <= weight_base + (entry[ENTRY_CONV_BIT] ? W_STEP_3X3 : W_STEP_1X1);
                        param_base  <= param_base + P_STEP;
                        layer_idx   <= idx_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
